// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch (IF) and
// load/store (LS). Each access is sequenced through a small FSM with a
// req/ack handshake toward memory. Generates byte enables and lane-replicated
// write data for sb/sh/sw, and sign/zero-extends lb/lh/lw/lbu/lhu read data.
//
// Parameters
//   STARVE_MAX  consecutive LS grants (while IF is pending) before IF is
//               forced first; legal range 1..15
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request (held until if_valid), word address
//   if_valid/if_rdata         1-cycle completion pulse and fetched word
//   ls_req/ls_we/ls_funct3    load/store request (held until ls_valid)
//   ls_addr/ls_wdata          byte address, store data
//   ls_valid/ls_rdata/ls_err  completion pulse, extended load data, misalign flag
//   mem_req/we/addr/be/wdata  memory request, held stable until mem_ack
//   mem_rdata/mem_ack         memory read word and same-cycle completion
//   busy                      FSM is not in IDLE
//
// Build option
//   MISALIGN_TRAP_EN  when defined, a misaligned LS request completes without
//                     touching memory and reports ls_err. When undefined,
//                     ls_err is tied low and misaligned accesses are issued
//                     with the low address bits ignored for lane selection.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; arbitrate and grant
// IF_WAIT | fetch issued, mem_req held until mem_ack
// LS_WAIT | load/store issued, mem_req held until mem_ack
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        LS_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  STARVE_MAX_C = 4'(STARVE_MAX);
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    state_t      state_q, state_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // funct3 and byte offset of the in-flight LS access, needed at ack time
    // to extract and extend the read data.
    logic [2:0]  ls_f3_q, ls_f3_d;
    logic [1:0]  ls_off_q, ls_off_d;

    logic        if_valid_q, if_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
`ifdef MISALIGN_TRAP_EN
    logic        ls_err_q, ls_err_d;
`endif

    logic        if_req_eff;
    logic        ls_req_eff;
    logic        grant_if;
    logic        grant_ls;
    logic        ls_trap;

    // -----------------------------------------------------------------------
    // Lane helpers. size = funct3[1:0]: 00 byte, 01 half, 1x word.
    // -----------------------------------------------------------------------
    function automatic logic [3:0] store_be(input logic [1:0] size,
                                            input logic [1:0] off);
        case (size)
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0]  size,
                                                input logic [31:0] wdata);
        case (size)
            2'b00:   store_wdata = {4{wdata[7:0]}};
            2'b01:   store_wdata = {2{wdata[15:0]}};
            default: store_wdata = wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        // off[0] is ignored for halves so a misaligned half still picks a lane
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'd0, b};
            3'b101:  load_extend = {16'd0, h};
            default: load_extend = rdata;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction
`endif

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        ls_f3_d      = ls_f3_q;
        ls_off_d     = ls_off_q;
        if_valid_d   = 1'b0;
        if_rdata_d   = 32'd0;
        ls_valid_d   = 1'b0;
        ls_rdata_d   = 32'd0;
`ifdef MISALIGN_TRAP_EN
        ls_err_d     = 1'b0;
`endif
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        ls_trap      = 1'b0;

        // A requester is still holding req during its own valid pulse; that
        // cycle must not start a second access for it.
        if_req_eff = if_req & ~if_valid_q;
        ls_req_eff = ls_req & ~ls_valid_q;

`ifdef MISALIGN_TRAP_EN
        ls_trap = is_misaligned(ls_funct3[1:0], ls_addr[1:0]);
`endif

        case (state_q)
            IDLE: begin
                if (if_req_eff && (!ls_req_eff || starve_cnt_q == STARVE_MAX_C)) begin
                    grant_if = 1'b1;
                end else if (ls_req_eff) begin
                    grant_ls = 1'b1;
                end

                if (grant_if) begin
                    state_d      = IF_WAIT;
                    starve_cnt_d = 4'd0;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr & WORD_MASK;
                    mem_be_d     = 4'b1111;
                    mem_wdata_d  = 32'd0;
                end else if (grant_ls) begin
                    if (if_req_eff && starve_cnt_q != 4'hF) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    ls_f3_d  = ls_funct3;
                    ls_off_d = ls_addr[1:0];
                    if (ls_trap) begin
                        // Completes next cycle from IDLE; memory never sees it.
                        ls_valid_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
                        ls_err_d   = 1'b1;
`endif
                    end else begin
                        state_d    = LS_WAIT;
                        mem_req_d  = 1'b1;
                        mem_we_d   = ls_we;
                        mem_addr_d = ls_addr & WORD_MASK;
                        if (ls_we) begin
                            mem_be_d    = store_be(ls_funct3[1:0], ls_addr[1:0]);
                            mem_wdata_d = store_wdata(ls_funct3[1:0], ls_wdata);
                        end else begin
                            mem_be_d    = 4'b1111;
                            mem_wdata_d = 32'd0;
                        end
                    end
                end
            end

            IF_WAIT: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    if_valid_d = 1'b1;
                    if_rdata_d = mem_rdata;
                end
            end

            LS_WAIT: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    ls_valid_d = 1'b1;
                    ls_rdata_d = mem_we_q ? 32'd0 : load_extend(ls_f3_q, ls_off_q, mem_rdata);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= 4'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            ls_f3_q      <= 3'd0;
            ls_off_q     <= 2'd0;
            if_valid_q   <= 1'b0;
            if_rdata_q   <= 32'd0;
            ls_valid_q   <= 1'b0;
            ls_rdata_q   <= 32'd0;
`ifdef MISALIGN_TRAP_EN
            ls_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            ls_f3_q      <= ls_f3_d;
            ls_off_q     <= ls_off_d;
            if_valid_q   <= if_valid_d;
            if_rdata_q   <= if_rdata_d;
            ls_valid_q   <= ls_valid_d;
            ls_rdata_q   <= ls_rdata_d;
`ifdef MISALIGN_TRAP_EN
            ls_err_q     <= ls_err_d;
`endif
        end
    end

    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_valid  = ls_valid_q;
    assign ls_rdata  = ls_rdata_q;
`ifdef MISALIGN_TRAP_EN
    assign ls_err    = ls_err_q;
`else
    assign ls_err    = 1'b0;
`endif
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_funct3 (ls_funct3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_if;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic        exp_memreq;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic is_if, input logic we,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int ack_dly, input logic exp_memreq,
                                input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                                input logic [31:0] exp_mwdata, input logic [31:0] exp_out,
                                input logic exp_err);
        vec_t v;
        v.name = name; v.is_if = is_if; v.we = we; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.ack_dly = ack_dly;
        v.exp_memreq = exp_memreq; v.exp_maddr = exp_maddr; v.exp_be = exp_be;
        v.exp_mwdata = exp_mwdata; v.exp_out = exp_out; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            ls_req    = 1'b1;
            ls_we     = v.we;
            ls_funct3 = v.f3;
            ls_addr   = v.addr;
            ls_wdata  = v.wdata;
        end
        tick();
        chk({v.name, " mem_req"}, mem_req, v.exp_memreq);
        if (v.exp_memreq) begin
            chk({v.name, " mem_addr"}, mem_addr, v.exp_maddr);
            chk({v.name, " mem_be"}, mem_be, v.exp_be);
            chk({v.name, " mem_wdata"}, mem_wdata, v.exp_mwdata);
            chk({v.name, " mem_we"}, mem_we, v.we);
            for (int i = 0; i < v.ack_dly; i++) begin
                tick();
                chk({v.name, " mem_req held"}, mem_req, 1'b1);
                chk({v.name, " mem_addr held"}, mem_addr, v.exp_maddr);
            end
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            chk({v.name, " mem_req drop"}, mem_req, 1'b0);
        end
        if (v.is_if) begin
            if_req = 1'b0;
            chk({v.name, " if_valid"}, if_valid, 1'b1);
            chk({v.name, " if_rdata"}, if_rdata, v.exp_out);
        end else begin
            ls_req = 1'b0;
            chk({v.name, " ls_valid"}, ls_valid, 1'b1);
            chk({v.name, " ls_rdata"}, ls_rdata, v.exp_out);
            chk({v.name, " ls_err"}, ls_err, v.exp_err);
        end
        tick();
        chk({v.name, " valid pulse"}, {if_valid, ls_valid}, 2'b00);
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; ls_req = 1'b0; ls_we = 1'b0;
        ls_funct3 = 3'd0; ls_addr = 32'd0; ls_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;

        // name, is_if, we, f3, addr, wdata, rdata, ack_dly, memreq, maddr, be, mwdata, out, err
        vecs.push_back(mk("if_fetch",  1, 0, 3'b010, 32'h100, 0, 32'h00500093, 1, 1, 32'h100, 4'hF, 0, 32'h00500093, 0));
        vecs.push_back(mk("lw",        0, 0, 3'b010, 32'h200, 0, 32'hDEADBEEF, 0, 1, 32'h200, 4'hF, 0, 32'hDEADBEEF, 0));
        vecs.push_back(mk("sb_203",    0, 1, 3'b000, 32'h203, 32'hAB, 0, 0, 1, 32'h200, 4'b1000, 32'hABABABAB, 0, 0));
        vecs.push_back(mk("sh_202",    0, 1, 3'b001, 32'h202, 32'h1234, 0, 2, 1, 32'h200, 4'b1100, 32'h12341234, 0, 0));
        vecs.push_back(mk("sb_201",    0, 1, 3'b000, 32'h201, 32'h123456CD, 0, 0, 1, 32'h200, 4'b0010, 32'hCDCDCDCD, 0, 0));
        vecs.push_back(mk("sw_204",    0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 0, 1, 32'h204, 4'hF, 32'hCAFEF00D, 0, 0));
        vecs.push_back(mk("lb_200",    0, 0, 3'b000, 32'h200, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'hFFFFFF85, 0));
        vecs.push_back(mk("lbu_200",   0, 0, 3'b100, 32'h200, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'h00000085, 0));
        vecs.push_back(mk("lh_202",    0, 0, 3'b001, 32'h202, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'hFFFF80F0, 0));
        vecs.push_back(mk("lhu_202",   0, 0, 3'b101, 32'h202, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'h000080F0, 0));
        vecs.push_back(mk("lb_201",    0, 0, 3'b000, 32'h201, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'h0000007F, 0));
        vecs.push_back(mk("lb_203",    0, 0, 3'b000, 32'h203, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'hFFFFFF80, 0));
        vecs.push_back(mk("lh_200",    0, 0, 3'b001, 32'h200, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'h00007F85, 0));
        vecs.push_back(mk("f3_011",    0, 0, 3'b011, 32'h208, 0, 32'h80F07F85, 0, 1, 32'h208, 4'hF, 0, 32'h80F07F85, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_201",    0, 0, 3'b010, 32'h201, 0, 32'h80F07F85, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("lh_203",    0, 0, 3'b001, 32'h203, 0, 32'h80F07F85, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("sh_201",    0, 1, 3'b001, 32'h201, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0, 1));
`else
        vecs.push_back(mk("lw_201",    0, 0, 3'b010, 32'h201, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'h80F07F85, 0));
        vecs.push_back(mk("lh_203",    0, 0, 3'b001, 32'h203, 0, 32'h80F07F85, 0, 1, 32'h200, 4'hF, 0, 32'hFFFF80F0, 0));
        vecs.push_back(mk("sh_201",    0, 1, 3'b001, 32'h201, 32'hBEEF, 0, 0, 1, 32'h200, 4'b0011, 32'hBEEFBEEF, 0, 0));
`endif

        // Reset state
        tick();
        tick();
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst valids", {if_valid, ls_valid, ls_err}, 3'b000);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_be_we", {mem_be, mem_we}, 5'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst rdata", if_rdata | ls_rdata, 32'd0);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Simultaneous request: LS first, IF granted back-to-back in ls_valid cycle
        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h200;
        tick();
        chk("prio first addr", mem_addr, 32'h200);
        chk("prio busy", busy, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'h11112222;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("prio ls_valid", ls_valid, 1'b1);
        chk("prio ls_rdata", ls_rdata, 32'h11112222);
        chk("prio if_valid early", if_valid, 1'b0);
        ls_req = 1'b0;
        tick();
        chk("prio b2b mem_req", mem_req, 1'b1);
        chk("prio b2b addr", mem_addr, 32'h300);
        mem_ack = 1'b1; mem_rdata = 32'h33334444;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("prio if_valid", if_valid, 1'b1);
        chk("prio if_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        tick();

        // Starvation: IF pending at each LS grant, but withdrawn in the ls_valid
        // cycle (fetch redirect) so it never gets the back-to-back slot.
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1; if_addr = 32'h400;
            ls_req = 1'b1; ls_addr = 32'h200; ls_funct3 = 3'b010; ls_we = 1'b0;
            tick();
            chk($sformatf("starve ls grant %0d", k), mem_addr, 32'h200);
            mem_ack = 1'b1; mem_rdata = 32'h0;
            tick();
            mem_ack = 1'b0;
            chk($sformatf("starve ls_valid %0d", k), ls_valid, 1'b1);
            if_req = 1'b0; ls_req = 1'b0;
            tick();
        end
        if_req = 1'b1; ls_req = 1'b1;
        tick();
        chk("starve if forced", mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'h55667788;
        tick();
        mem_ack = 1'b0;
        chk("starve if_valid", if_valid, 1'b1);
        chk("starve if_rdata", if_rdata, 32'h55667788);
        if_req = 1'b0;
        tick();
        chk("starve ls after if", mem_addr, 32'h200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        ls_req = 1'b0;
        tick();
        if_req = 1'b1; ls_req = 1'b1;
        tick();
        chk("starve cnt cleared", mem_addr, 32'h200);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        if_req = 1'b0; ls_req = 1'b0;
        tick();

        // No ack: wait indefinitely; then reset mid-access drops it
        ls_req = 1'b1; ls_addr = 32'h210; ls_funct3 = 3'b010; ls_we = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) tick();
        chk("noack still req", mem_req, 1'b1);
        chk("noack busy", busy, 1'b1);
        chk("noack addr", mem_addr, 32'h210);
        rst = 1'b1; ls_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99999999;
        tick();
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("midrst mem_req", mem_req, 1'b0);
        chk("midrst busy", busy, 1'b0);
        chk("midrst ls_valid", ls_valid, 1'b0);
        tick();
        chk("midrst ls_valid after", ls_valid, 1'b0);
        chk("midrst busy after", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
